// File: rtl/lut_wvf_gen_mc.sv
// Multi-channel LUT waveform generator.
// N_CH tables of DEPTH samples. One table is selected at trigger time and
// swept with a programmable address step, either once or continuously.
// The sample path has two register stages, both of which carry valid and
// end-of-sweep flags:
//   - the ROM read stage (rom_q)
//   - the output stage (DATA_OUT)
module lut_wvf_gen_mc #(
  parameter int BITWIDTH_OUT = 16,
  parameter int DEPTH        = 32,
  parameter int N_CH         = 4,
  parameter     INIT_FILE    = "",
  localparam int AW = $clog2(DEPTH),
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    CLK_SYS,
  input  logic                    RSTN,
  input  logic                    EN,
  input  logic                    TRGG_START_CALC,
  input  logic                    MODE,
  input  logic [CW-1:0]           CH_SEL,
  input  logic [AW-1:0]           STEP,
  output logic [BITWIDTH_OUT-1:0] DATA_OUT,
  output logic                    DATA_VALID,
  output logic                    LUT_END,
  output logic                    BUSY,
  output logic [25:0]             DATA_HEAD
);

  // Channel bits beyond N_CH-1 are masked so a single-table build always reads table 0.
  localparam logic [CW-1:0] CH_MASK = CW'(N_CH - 1);
  localparam logic [4:0]    BW5     = 5'(BITWIDTH_OUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Default table content: word(c,i) = (c << AW) | i, truncated/extended to the sample width.
  function automatic logic [BITWIDTH_OUT-1:0] rom_word(input logic [CW-1:0] c,
                                                       input logic [AW-1:0] i);
    logic [CW+AW-1:0] full;
    full = {c, i};
    return BITWIDTH_OUT'(full);
  endfunction

  state_t                  state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [AW-1:0]           step_q, step_d;
  logic [CW-1:0]           ch_q, ch_d;
  logic                    mode_q, mode_d;
  logic                    stop_q, stop_d;
  logic                    busy_q, busy_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_last_q, rd_last_d;
  logic [BITWIDTH_OUT-1:0] rom_q, rom_d;
  logic [BITWIDTH_OUT-1:0] data_out_q, data_out_d;
  logic                    data_valid_q, data_valid_d;
  logic                    lut_end_q, lut_end_d;
  logic [AW:0]             next_addr_s;
  logic                    stop_now_s;

  // Sweep control: latch settings on trigger, walk the address, decide on wrap/stop/drain.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    step_d      = step_q;
    ch_d        = ch_q;
    mode_d      = mode_q;
    stop_d      = stop_q;
    busy_d      = busy_q;
    rd_valid_d  = 1'b0;
    rd_last_d   = 1'b0;
    rom_d       = rom_q;
    // Both operands are below DEPTH = 2**AW, so the carry bit alone flags addr+step >= DEPTH.
    next_addr_s = {1'b0, addr_q} + {1'b0, step_q};
    // A stop seen on the very cycle of the last read still ends this sweep.
    stop_now_s  = stop_q | (TRGG_START_CALC & mode_q);

    case (state_q)
      S_IDLE: begin
        if (TRGG_START_CALC) begin
          mode_d  = MODE;
          ch_d    = CH_SEL & CH_MASK;
          step_d  = (STEP == '0) ? AW'(1) : STEP;
          addr_d  = '0;
          stop_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          busy_d = 1'b0;
        end
      end

      S_RUN: begin
        if (TRGG_START_CALC && mode_q) begin
          stop_d = 1'b1;
        end else begin
          stop_d = stop_q;
        end
        if (EN) begin
          rd_valid_d = 1'b1;
          rom_d      = rom_word(ch_q, addr_q);
          if (next_addr_s[AW]) begin
            rd_last_d = 1'b1;
            addr_d    = '0;
            if (!mode_q || stop_now_s) begin
              state_d = S_DRAIN;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            addr_d = next_addr_s[AW-1:0];
          end
        end else begin
          addr_d = addr_q;
        end
      end

      S_DRAIN: begin
        // The final sample is moving to the output this cycle; release on the next.
        if (!rd_valid_q) begin
          busy_d  = 1'b0;
          stop_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end

      default: begin
        busy_d  = 1'b0;
        stop_d  = 1'b0;
        addr_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output stage: present the ROM word one cycle after the read, hold it while paused.
  always_comb begin
    data_valid_d = rd_valid_q;
    lut_end_d    = rd_valid_q & rd_last_q;
    if (rd_valid_q) begin
      data_out_d = rom_q;
    end else begin
      data_out_d = data_out_q;
    end
  end

  // State, sweep settings and pipeline registers; reset aborts any sweep in flight.
  always_ff @(posedge CLK_SYS or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      step_q       <= AW'(1);
      ch_q         <= '0;
      mode_q       <= 1'b0;
      stop_q       <= 1'b0;
      busy_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rom_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      lut_end_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      step_q       <= step_d;
      ch_q         <= ch_d;
      mode_q       <= mode_d;
      stop_q       <= stop_d;
      busy_q       <= busy_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      rom_q        <= rom_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      lut_end_q    <= lut_end_d;
    end
  end

  assign DATA_OUT   = data_out_q;
  assign DATA_VALID = data_valid_q;
  assign LUT_END    = lut_end_q;
  assign BUSY       = busy_q;
  assign DATA_HEAD  = {4'd3, 6'd0, 6'd22, 5'd0, BW5};

endmodule
